shift_tx_scheduler: RTL

Sequencer and round-robin arbiter for the 8-bit parallel-load, LSB-first serial shift register in the Proyecto2 datapath. Up to NREQ requesters post bytes. The block grants one requester at a time, drives that register's load and data_in inputs, counts out the 8 shift cycles, and flags the cycles in which the register's serial output carries a valid bit.

---
 rtl/shift_tx_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/shift_tx_scheduler.sv
// Round-robin sequencer feeding an 8-bit LSB-first parallel-load shift register.
// Grants one requester per frame, pulses load, counts 8 shifts and marks valid serial bits.
module shift_tx_scheduler #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned OWN_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              sr_load,
    output logic [7:0]        sr_data,
    output logic              bit_valid,
    output logic [2:0]        bit_idx,
    output logic [OWN_W-1:0]  owner,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LAST  = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [OWN_W-1:0]  ptr_q,       ptr_d;
    logic [OWN_W-1:0]  owner_q,     owner_d;
    logic [BYTE_W-1:0] sr_data_q,   sr_data_d;
    logic [NREQ-1:0]   ack_q,       ack_d;
    logic              sr_load_q,   sr_load_d;
    logic              bit_valid_q, bit_valid_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              hi_vld_c;
    logic [OWN_W-1:0]  hi_idx_c;
    logic              any_req_c;
    logic [OWN_W-1:0]  lo_idx_c;
    logic [OWN_W-1:0]  grant_idx_c;
    logic [NREQ-1:0]   grant_oh_c;
    logic [BYTE_W-1:0] grant_data_c;
    logic              arb_c;

    // Round-robin search: lowest asserted index at or above ptr, else lowest overall (wrap).
    always_comb begin
        hi_vld_c  = 1'b0;
        hi_idx_c  = '0;
        any_req_c = 1'b0;
        lo_idx_c  = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i] && (OWN_W'(i) >= ptr_q)) begin
                hi_vld_c = 1'b1;
                hi_idx_c = OWN_W'(i);
            end
            if (req[i]) begin
                any_req_c = 1'b1;
                lo_idx_c  = OWN_W'(i);
            end
        end
        grant_idx_c = hi_vld_c ? hi_idx_c : lo_idx_c;
    end

    // One-hot grant and byte mux for the chosen requester.
    always_comb begin
        grant_oh_c   = '0;
        grant_data_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx_c == OWN_W'(i)) begin
                grant_oh_c[i] = 1'b1;
                grant_data_c  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        sr_data_d = sr_data_q;
        ack_d     = '0;
        arb_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb_c = 1'b1;
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                count_d = '0;
            end
            S_SHIFT: begin
                if (count_q == CNT_LAST) begin
                    state_d = S_LAST;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_LAST: begin
                arb_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        if (arb_c) begin
            if (any_req_c) begin
                state_d   = S_LOAD;
                count_d   = '0;
                ack_d     = grant_oh_c;
                owner_d   = grant_idx_c;
                sr_data_d = grant_data_c;
                ptr_d     = (grant_idx_c == OWN_W'(NREQ - 1)) ? '0
                                                              : grant_idx_c + OWN_W'(1);
            end else begin
                state_d = S_IDLE;
                count_d = '0;
            end
        end

        sr_load_d   = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_LAST);
        bit_valid_d = 1'b0;
        bit_idx_d   = '0;
        // Serial output lags the count by one: first SHIFT cycle is still high-Z.
        if (state_d == S_LAST) begin
            bit_valid_d = 1'b1;
            bit_idx_d   = 3'd7;
        end else if ((state_d == S_SHIFT) && (count_d != '0)) begin
            bit_valid_d = 1'b1;
            bit_idx_d   = 3'(count_d - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            sr_data_q   <= '0;
            ack_q       <= '0;
            sr_load_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            sr_data_q   <= sr_data_d;
            ack_q       <= ack_d;
            sr_load_q   <= sr_load_d;
            bit_valid_q <= bit_valid_d;
            bit_idx_q   <= bit_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ack       = ack_q;
    assign sr_load   = sr_load_q;
    assign sr_data   = sr_data_q;
    assign bit_valid = bit_valid_q;
    assign bit_idx   = bit_idx_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
